// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
// Issues one ROM read per cycle while there is room for the returning word,
// pairs each returning word with the PC that requested it, and buffers up to
// two {pc, instr} pairs for the decode stage. A redirect from execute flushes
// the buffer and the in-flight request, then restarts fetch at the target.
// Optional build macro: FETCH_DEBUG_EN adds debug_IF_pc / debug_IF_bufCount.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i_fetch,
  input  logic        reset_i_fetch,
  output logic        romEn_o,
  output logic [31:0] romAddr_o,
  input  logic [31:0] romData_i,
  input  logic        idReady_i,
  output logic        ifidValid_o,
  output logic [31:0] ifidPcAddr_o,
  output logic [31:0] ifidInstr_o,
  input  logic        redirect_i,
  input  logic [31:0] redirectPc_i
`ifdef FETCH_DEBUG_EN
  ,
  output logic [31:0] debug_IF_pc,
  output logic [1:0]  debug_IF_bufCount
`endif
);

  // Word-aligned reset PC; the low two bits of the parameter are ignored.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam int          DEPTH            = 2;

  // Architectural fetch state
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        inflight_q;
  logic [31:0] issue_pc_q;

  // Two-entry buffer of {pc, instr}, ring-addressed by one-bit pointers
  logic [31:0] fifo_pc_q    [DEPTH];
  logic [31:0] fifo_instr_q [DEPTH];
  logic        rd_ptr_q;
  logic        rd_ptr_next;
  logic        wr_ptr_q;
  logic        wr_ptr_next;
  logic [1:0]  count_q;
  logic [1:0]  count_next;

  // Per-cycle control
  logic             pop;
  logic             push;
  logic             issue;
  logic [2:0]       occupancy;
  logic [31:0]      redirect_target;
  logic [DEPTH-1:0] wr_en;

  assign redirect_target = {redirectPc_i[31:2], 2'b00};

  // Handshake, response acceptance and issue decision.
  // Occupancy counts buffered words plus the word still in flight, less the
  // word leaving this cycle; a new request is only made if its reply will
  // find a free slot. Issue is also held off while reset is asserted so the
  // ROM sees no request during reset.
  always_comb begin
    ifidValid_o = (count_q != 2'd0) && !redirect_i;
    pop         = ifidValid_o && idReady_i;
    push        = inflight_q && !redirect_i;
    occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue       = !reset_i_fetch && !redirect_i && (occupancy < 3'd2);
  end

  assign romEn_o   = issue;
  assign romAddr_o = pc_q;

  // Present the buffer head; an empty buffer shows zeros.
  always_comb begin
    ifidPcAddr_o = 32'd0;
    ifidInstr_o  = 32'd0;
    if (count_q != 2'd0) begin
      ifidPcAddr_o = fifo_pc_q[rd_ptr_q];
      ifidInstr_o  = fifo_instr_q[rd_ptr_q];
    end
  end

  // Next PC, pointers and occupancy; a redirect overrides issue, push and pop.
  always_comb begin
    pc_next     = pc_q;
    count_next  = count_q;
    rd_ptr_next = rd_ptr_q;
    wr_ptr_next = wr_ptr_q;
    if (redirect_i) begin
      pc_next     = redirect_target;
      count_next  = 2'd0;
      rd_ptr_next = 1'b0;
      wr_ptr_next = 1'b0;
    end else begin
      if (issue) begin
        // Natural 32-bit wrap takes FFFF_FFFC back to 0.
        pc_next = pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_next = ~rd_ptr_q;
      end
      if (push) begin
        wr_ptr_next = ~wr_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_next = count_q + 2'd1;
        2'b01:   count_next = count_q - 2'd1;
        default: count_next = count_q;
      endcase
    end
  end

  // PC, request tracking and the captured issuing PC.
  // issue_pc_q holds the address of the outstanding request so the word that
  // arrives next cycle is tagged with the PC that fetched it.
  always_ff @(posedge clk_i_fetch or posedge reset_i_fetch) begin
    if (reset_i_fetch) begin
      pc_q       <= RESET_PC_ALIGNED;
      inflight_q <= 1'b0;
      issue_pc_q <= 32'd0;
    end else begin
      pc_q       <= pc_next;
      inflight_q <= issue;
      if (issue) begin
        issue_pc_q <= pc_q;
      end
    end
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk_i_fetch or posedge reset_i_fetch) begin
    if (reset_i_fetch) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_next;
      rd_ptr_q <= rd_ptr_next;
      wr_ptr_q <= wr_ptr_next;
    end
  end

  // One write strobe per buffer slot
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_q == 1'(gi));
  end

  // Buffer storage: the arriving ROM word is written with its issuing PC.
  always_ff @(posedge clk_i_fetch or posedge reset_i_fetch) begin
    if (reset_i_fetch) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]    <= 32'd0;
        fifo_instr_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          fifo_pc_q[i]    <= issue_pc_q;
          fifo_instr_q[i] <= romData_i;
        end
      end
    end
  end

`ifdef FETCH_DEBUG_EN
  // Debug taps mirror internal state combinationally.
  assign debug_IF_pc       = pc_q;
  assign debug_IF_bufCount = count_q;
`else
  // Debug taps are not built; behaviour is otherwise identical.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed values.
// Two instances share stimulus: dut (RESET_PC = 0) and dut_hi
// (RESET_PC = FFFF_FFF8) for the PC wrap case. Each ROM model returns
// (addr >> 2) + 1 one cycle after a request, and DEAD_BEEF otherwise.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        rom_en, valid;
  logic [31:0] rom_addr, rom_data, pc, instr;
  logic        rom_en_h, valid_h;
  logic [31:0] rom_addr_h, rom_data_h, pc_h, instr_h;

  int n_cmp = 0;
  int n_mis = 0;

`ifdef FETCH_DEBUG_EN
  logic [31:0] dbg_pc, dbg_pc_h;
  logic [1:0]  dbg_cnt, dbg_cnt_h;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i_fetch   (clk),
    .reset_i_fetch (rst),
    .romEn_o       (rom_en),
    .romAddr_o     (rom_addr),
    .romData_i     (rom_data),
    .idReady_i     (id_ready),
    .ifidValid_o   (valid),
    .ifidPcAddr_o  (pc),
    .ifidInstr_o   (instr),
    .redirect_i    (redirect),
    .redirectPc_i  (redirect_pc)
`ifdef FETCH_DEBUG_EN
    ,
    .debug_IF_pc       (dbg_pc),
    .debug_IF_bufCount (dbg_cnt)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk_i_fetch   (clk),
    .reset_i_fetch (rst),
    .romEn_o       (rom_en_h),
    .romAddr_o     (rom_addr_h),
    .romData_i     (rom_data_h),
    .idReady_i     (id_ready),
    .ifidValid_o   (valid_h),
    .ifidPcAddr_o  (pc_h),
    .ifidInstr_o   (instr_h),
    .redirect_i    (redirect),
    .redirectPc_i  (redirect_pc)
`ifdef FETCH_DEBUG_EN
    ,
    .debug_IF_pc       (dbg_pc_h),
    .debug_IF_bufCount (dbg_cnt_h)
`endif
  );

  // ROM models: ROM[i] = i + 1, one-cycle read latency
  always @(posedge clk) begin
    rom_data   <= rom_en   ? (rom_addr   >> 2) + 32'd1 : 32'hDEAD_BEEF;
    rom_data_h <= rom_en_h ? (rom_addr_h >> 2) + 32'd1 : 32'hDEAD_BEEF;
  end

  // Hold reset over two edges, release 1ns after an edge; returns inside cycle 0.
  task automatic do_reset(input logic ready);
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; id_ready = ready;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  // Advance to the next cycle, apply inputs, let outputs settle.
  task automatic cyc(input logic ready, input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    id_ready = ready; redirect = redir; redirect_pc = rpc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (rom_en !== 1'b0) begin n_mis++; $display("FAIL reset_rom_en got %b want 0", rom_en); end
    n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid got %b want 0", valid); end
    n_cmp++; if (pc !== 32'd0) begin n_mis++; $display("FAIL reset_pc got %h want 0", pc); end
    n_cmp++; if (instr !== 32'd0) begin n_mis++; $display("FAIL reset_instr got %h want 0", instr); end
    n_cmp++; if (rom_addr !== 32'd0) begin n_mis++; $display("FAIL reset_rom_addr got %h want 0", rom_addr); end
    n_cmp++; if (rom_en_h !== 1'b0) begin n_mis++; $display("FAIL reset_rom_en_hi got %b want 0", rom_en_h); end
    n_cmp++; if (rom_addr_h !== 32'hFFFF_FFF8) begin n_mis++; $display("FAIL reset_rom_addr_hi got %h want fffffff8", rom_addr_h); end
    $display("test_reset done");
  endtask

  // Continuous streaming with decode always ready
  task automatic test_stream();
    do_reset(1'b1);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) cyc(1'b1, 1'b0, 32'd0);
      n_cmp++; if (rom_en !== 1'b1) begin n_mis++; $display("FAIL stream_rom_en c%0d got %b want 1", c, rom_en); end
      n_cmp++; if (rom_addr !== 32'(4 * c)) begin n_mis++; $display("FAIL stream_rom_addr c%0d got %h want %h", c, rom_addr, 32'(4 * c)); end
      if (c < 2) begin
        n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL stream_valid c%0d got %b want 0", c, valid); end
      end else begin
        n_cmp++; if (valid !== 1'b1) begin n_mis++; $display("FAIL stream_valid c%0d got %b want 1", c, valid); end
        n_cmp++; if (pc !== 32'(4 * (c - 2))) begin n_mis++; $display("FAIL stream_pc c%0d got %h want %h", c, pc, 32'(4 * (c - 2))); end
        n_cmp++; if (instr !== 32'(c - 1)) begin n_mis++; $display("FAIL stream_instr c%0d got %h want %h", c, instr, 32'(c - 1)); end
      end
    end
    $display("test_stream done");
  endtask

  // Decode stalls for cycles 4..8; head held at pc 8, no issue while full
  task automatic test_stall();
    logic ready;
    do_reset(1'b1);
    for (int c = 0; c <= 12; c++) begin
      ready = (c >= 4 && c <= 8) ? 1'b0 : 1'b1;
      if (c > 0) cyc(ready, 1'b0, 32'd0);
      if (c >= 4 && c <= 8) begin
        n_cmp++; if (valid !== 1'b1) begin n_mis++; $display("FAIL stall_valid c%0d got %b want 1", c, valid); end
        n_cmp++; if (pc !== 32'd8) begin n_mis++; $display("FAIL stall_pc c%0d got %h want 8", c, pc); end
        n_cmp++; if (instr !== 32'd3) begin n_mis++; $display("FAIL stall_instr c%0d got %h want 3", c, instr); end
        n_cmp++; if (rom_en !== 1'b0) begin n_mis++; $display("FAIL stall_rom_en c%0d got %b want 0", c, rom_en); end
      end else if (c >= 9) begin
        n_cmp++; if (valid !== 1'b1) begin n_mis++; $display("FAIL resume_valid c%0d got %b want 1", c, valid); end
        n_cmp++; if (pc !== 32'(8 + 4 * (c - 9))) begin n_mis++; $display("FAIL resume_pc c%0d got %h want %h", c, pc, 32'(8 + 4 * (c - 9))); end
        n_cmp++; if (instr !== 32'(3 + (c - 9))) begin n_mis++; $display("FAIL resume_instr c%0d got %h want %h", c, instr, 32'(3 + (c - 9))); end
        n_cmp++; if (rom_en !== 1'b1) begin n_mis++; $display("FAIL resume_rom_en c%0d got %b want 1", c, rom_en); end
        n_cmp++; if (rom_addr !== 32'(16 + 4 * (c - 9))) begin n_mis++; $display("FAIL resume_rom_addr c%0d got %h want %h", c, rom_addr, 32'(16 + 4 * (c - 9))); end
      end
    end
    $display("test_stall done");
  endtask

  // Redirect at cycle 5 to 0x103 while streaming
  task automatic test_redirect();
    do_reset(1'b1);
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) cyc(1'b1, (c == 5), (c == 5) ? 32'h0000_0103 : 32'hFFFF_FFFF);
      case (c)
        5: begin
          n_cmp++; if (rom_en !== 1'b0) begin n_mis++; $display("FAIL redir_n_rom_en got %b want 0", rom_en); end
          n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL redir_n_valid got %b want 0", valid); end
        end
        6: begin
          n_cmp++; if (rom_en !== 1'b1) begin n_mis++; $display("FAIL redir_n1_rom_en got %b want 1", rom_en); end
          n_cmp++; if (rom_addr !== 32'h100) begin n_mis++; $display("FAIL redir_n1_rom_addr got %h want 100", rom_addr); end
          n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL redir_n1_valid got %b want 0", valid); end
        end
        7: begin
          n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL redir_n2_valid got %b want 0", valid); end
          n_cmp++; if (rom_addr !== 32'h104) begin n_mis++; $display("FAIL redir_n2_rom_addr got %h want 104", rom_addr); end
        end
        8: begin
          n_cmp++; if (valid !== 1'b1) begin n_mis++; $display("FAIL redir_n3_valid got %b want 1", valid); end
          n_cmp++; if (pc !== 32'h100) begin n_mis++; $display("FAIL redir_n3_pc got %h want 100", pc); end
          n_cmp++; if (instr !== 32'h41) begin n_mis++; $display("FAIL redir_n3_instr got %h want 41", instr); end
        end
        9: begin
          n_cmp++; if (pc !== 32'h104) begin n_mis++; $display("FAIL redir_n4_pc got %h want 104", pc); end
          n_cmp++; if (instr !== 32'h42) begin n_mis++; $display("FAIL redir_n4_instr got %h want 42", instr); end
        end
        default: ;
      endcase
    end
    $display("test_redirect done");
  endtask

  // Redirect at cycle 7 to 0x200 with buffer full and decode stalled
  task automatic test_redirect_stall();
    do_reset(1'b1);
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) cyc((c < 4), (c == 7), (c == 7) ? 32'h0000_0200 : 32'd0);
      case (c)
        6: begin
          n_cmp++; if (valid !== 1'b1) begin n_mis++; $display("FAIL rs_full_valid got %b want 1", valid); end
          n_cmp++; if (pc !== 32'd8) begin n_mis++; $display("FAIL rs_full_pc got %h want 8", pc); end
          n_cmp++; if (rom_en !== 1'b0) begin n_mis++; $display("FAIL rs_full_rom_en got %b want 0", rom_en); end
        end
        7: begin
          n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL rs_n_valid got %b want 0", valid); end
          n_cmp++; if (rom_en !== 1'b0) begin n_mis++; $display("FAIL rs_n_rom_en got %b want 0", rom_en); end
        end
        8: begin
          n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL rs_n1_valid got %b want 0", valid); end
          n_cmp++; if (rom_en !== 1'b1) begin n_mis++; $display("FAIL rs_n1_rom_en got %b want 1", rom_en); end
          n_cmp++; if (rom_addr !== 32'h200) begin n_mis++; $display("FAIL rs_n1_rom_addr got %h want 200", rom_addr); end
        end
        9: begin
          n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL rs_n2_valid got %b want 0", valid); end
        end
        10, 11: begin
          n_cmp++; if (valid !== 1'b1) begin n_mis++; $display("FAIL rs_valid c%0d got %b want 1", c, valid); end
          n_cmp++; if (pc !== 32'h200) begin n_mis++; $display("FAIL rs_pc c%0d got %h want 200", c, pc); end
          n_cmp++; if (instr !== 32'h81) begin n_mis++; $display("FAIL rs_instr c%0d got %h want 81", c, instr); end
        end
        default: ;
      endcase
    end
    $display("test_redirect_stall done");
  endtask

  // PC wrap from FFFF_FFFC to 0 on the high-reset instance
  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    logic [31:0] exp_pc [3];
    logic [31:0] exp_instr [3];
    exp_addr[0]  = 32'hFFFF_FFF8; exp_addr[1]  = 32'hFFFF_FFFC; exp_addr[2]  = 32'h0000_0000;
    exp_pc[0]    = 32'hFFFF_FFF8; exp_pc[1]    = 32'hFFFF_FFFC; exp_pc[2]    = 32'h0000_0000;
    exp_instr[0] = 32'h3FFF_FFFF; exp_instr[1] = 32'h4000_0000; exp_instr[2] = 32'h0000_0001;
    do_reset(1'b1);
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) cyc(1'b1, 1'b0, 32'd0);
      if (c <= 2) begin
        n_cmp++; if (rom_addr_h !== exp_addr[c]) begin n_mis++; $display("FAIL wrap_rom_addr c%0d got %h want %h", c, rom_addr_h, exp_addr[c]); end
      end
      if (c >= 2) begin
        n_cmp++; if (valid_h !== 1'b1) begin n_mis++; $display("FAIL wrap_valid c%0d got %b want 1", c, valid_h); end
        n_cmp++; if (pc_h !== exp_pc[c - 2]) begin n_mis++; $display("FAIL wrap_pc c%0d got %h want %h", c, pc_h, exp_pc[c - 2]); end
        n_cmp++; if (instr_h !== exp_instr[c - 2]) begin n_mis++; $display("FAIL wrap_instr c%0d got %h want %h", c, instr_h, exp_instr[c - 2]); end
      end
    end
    $display("test_wrap done");
  endtask

  // Asynchronous reset mid-cycle with a full buffer, then restart
  task automatic test_async_reset();
    do_reset(1'b1);
    for (int c = 1; c <= 5; c++) cyc((c < 4), 1'b0, 32'd0);
    n_cmp++; if (pc !== 32'd8) begin n_mis++; $display("FAIL areset_pre_pc got %h want 8", pc); end
    n_cmp++; if (rom_en !== 1'b0) begin n_mis++; $display("FAIL areset_pre_rom_en got %b want 0", rom_en); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rom_en !== 1'b0) begin n_mis++; $display("FAIL areset_rom_en got %b want 0", rom_en); end
    n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL areset_valid got %b want 0", valid); end
    n_cmp++; if (pc !== 32'd0) begin n_mis++; $display("FAIL areset_pc got %h want 0", pc); end
    n_cmp++; if (instr !== 32'd0) begin n_mis++; $display("FAIL areset_instr got %h want 0", instr); end
    n_cmp++; if (rom_addr !== 32'd0) begin n_mis++; $display("FAIL areset_rom_addr got %h want 0", rom_addr); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; id_ready = 1'b1;
    #1;
    n_cmp++; if (rom_en !== 1'b1) begin n_mis++; $display("FAIL restart_rom_en got %b want 1", rom_en); end
    n_cmp++; if (rom_addr !== 32'd0) begin n_mis++; $display("FAIL restart_rom_addr got %h want 0", rom_addr); end
    cyc(1'b1, 1'b0, 32'd0);
    n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL restart_c1_valid got %b want 0", valid); end
    cyc(1'b1, 1'b0, 32'd0);
    n_cmp++; if (valid !== 1'b1) begin n_mis++; $display("FAIL restart_c2_valid got %b want 1", valid); end
    n_cmp++; if (pc !== 32'd0) begin n_mis++; $display("FAIL restart_c2_pc got %h want 0", pc); end
    n_cmp++; if (instr !== 32'd1) begin n_mis++; $display("FAIL restart_c2_instr got %h want 1", instr); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog timeout reached got running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset; bits [1:0] are treated as 0.
REQ-002 Port clk_i_fetch  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset_i_fetch  input  1  asynchronous, active-high reset.
REQ-004 Port romEn_o  output  1  instruction-ROM read request this cycle.
REQ-005 Port romAddr_o  output  32  byte address of the request, equal to pc_q.
REQ-006 Port romData_i  input  32  ROM word, valid exactly one cycle after its romEn_o.
REQ-007 Port idReady_i  input  1  decode stage accepts the IF/ID word this cycle.
REQ-008 Port ifidValid_o  output  1  IF/ID word valid.
REQ-009 Port ifidPcAddr_o  output  32  PC of the presented instruction.
REQ-010 Port ifidInstr_o  output  32  presented instruction.
REQ-011 Port redirect_i  input  1  branch/jump redirect from execute; flushes fetch.
REQ-012 Port redirectPc_i  input  32  redirect target; bits [1:0] are forced to 0.
REQ-013 Port debug_IF_pc  output  32  pc_q; exists only under FETCH_DEBUG_EN.
REQ-014 Port debug_IF_bufCount  output  2  buffer occupancy; exists only under FETCH_DEBUG_EN.

Function
REQ-015 State: pc_q (32b), inflight_q (1b), 2-entry FIFO of {pc, instr}, count_q (0..2).
REQ-016 Transfer: pop = ifidValid_o & idReady_i.
REQ-017 Issue: romEn_o = !redirect_i & (count_q + inflight_q - pop < 2); on issue, pc_q <= pc_q + 4, with wrap 32'hFFFF_FFFC -> 0.
REQ-018 Request tracking: inflight_q <= romEn_o each cycle.
REQ-019 Capture: the issuing PC is held so that the arriving romData_i pairs with the address that requested it.
REQ-020 Response: when inflight_q=1 and redirect_i=0, push {issued pc, romData_i} into the FIFO.
REQ-021 Simultaneous push and pop: both occur; count_q is unchanged.
REQ-022 Outputs: ifidValid_o = (count_q != 0) & !redirect_i; ifidPcAddr_o and ifidInstr_o show the FIFO head.
- When count_q = 0, ifidPcAddr_o and ifidInstr_o are 0.
REQ-023 Stall: while idReady_i = 0, the head is held stable, count_q never exceeds 2, and no word is dropped or duplicated.
REQ-024 Redirect in cycle N (overrides pop, push and issue):
- FIFO cleared; inflight_q <= 0, so the cycle N+1 ROM data is discarded.
- pc_q <= redirectPc_i & ~3.
- Cycle N+1: romEn_o=1, romAddr_o=target.
- Cycle N+2: word pushed; ifidValid_o=1 from N+3.
REQ-025 Latency and throughput: request to ifidValid_o is 2 cycles; with idReady_i held at 1, sustained throughput is 1 instruction/cycle.
REQ-026 Redirect during stall: same as REQ-024; stalled words are discarded.

Reset
REQ-027 Asynchronous assertion clears state immediately:
- pc_q = RESET_PC, inflight_q = 0, count_q = 0, FIFO entries = 0.
- romEn_o = 0, ifidValid_o = 0, ifidPcAddr_o = 0, ifidInstr_o = 0.
REQ-028 Reset asserted mid-operation discards all buffered and in-flight words.
REQ-029 First romEn_o=1, with romAddr_o = RESET_PC, occurs in the first cycle after reset deasserts.

Configuration
REQ-030 Macro FETCH_DEBUG_EN.
- Defined: debug_IF_pc and debug_IF_bufCount exist and mirror pc_q and count_q combinationally.
- Undefined: neither port exists; all other behaviour is identical.

Verification
REQ-031 Reset, ROM[i] = i+1, idReady_i = 1 -> ifidPcAddr_o = 0, 4, 8, ... on consecutive cycles from cycle 2 after reset release, with ifidInstr_o = 1, 2, 3, ...
REQ-032 idReady_i = 0 for 5 cycles mid-stream -> count_q saturates at 2 and romEn_o = 0 while full; after release, PCs continue with no gap or duplicate.
REQ-033 redirect_i = 1, redirectPc_i = 32'h0000_0103 at cycle N -> romAddr_o = 32'h100 at N+1; next valid word has pc 32'h100 at N+3; the stale in-flight word never appears.
REQ-034 Redirect with FIFO full and idReady_i = 0 -> ifidValid_o = 0 at N+1, and the first valid word is the target.
REQ-035 RESET_PC = 32'hFFFF_FFF8 -> sequential PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 Assert reset_i_fetch between clock edges while count_q = 2 -> all outputs are 0 immediately, and fetch restarts at RESET_PC.
